// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: one access in flight against a gnt/rvalid memory port, with lane formatting and timeout faults.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              halt,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              resp_misalign,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    logic        accept;
    logic        bad_size;
    logic        req_misalign;
    logic        to_hit;
    logic [3:0]  strb_fmt;
    logic [31:0] wdata_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_fmt;

    assign accept   = (state_q == S_IDLE) && req_valid && !halt;
    assign bad_size = (req_size == 2'b11);
    assign to_hit   = TO_EN && (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    // Store formatting works off the latched request so the bus stays stable while stalled.
    always_comb begin
        strb_fmt  = 4'b1111;
        wdata_fmt = wdata_q;
        case (size_q)
            2'b00: begin
                strb_fmt  = 4'b0001 << addr_q[1:0];
                wdata_fmt = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb_fmt  = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{wdata_q[15:0]}};
            end
            default: begin
                strb_fmt  = 4'b1111;
                wdata_fmt = wdata_q;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_fmt = mem_rdata;
        case (size_q)
            2'b00:   load_fmt = {{24{!uns_q && ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = {{16{!uns_q && ld_half[15]}}, ld_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    fault_d = bad_size || req_misalign;
                    cnt_d   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_d = !bad_size && req_misalign;
`endif
                    state_d = (bad_size || req_misalign) ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (TO_EN) cnt_d = cnt_q + CNT_W'(1);
                if (mem_gnt) begin
                    state_d = we_q ? S_RESP : S_WAIT;
                end else if (to_hit) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (TO_EN) cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    rdata_d = load_fmt;
                    state_d = S_RESP;
                end else if (to_hit) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Bus and response outputs are forced to zero outside their owning state.
    assign req_ready  = (state_q == S_IDLE) && !halt;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
    assign resp_fault = (state_q == S_RESP) && fault_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_misalign = (state_q == S_RESP) && misalign_q;
`else
    assign resp_misalign = 1'b0;
`endif

    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = (state_q == S_REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_we    = (state_q == S_REQ) && we_q;
    assign mem_wstrb = (state_q == S_REQ && we_q) ? strb_fmt : 4'b0000;
    assign mem_wdata = (state_q == S_REQ && we_q) ? wdata_fmt : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected responses are queued at issue time and popped when resp_valid fires.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid, req_we, req_unsigned, halt;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_fault, resp_misalign;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        to_req_valid, to_req_ready, to_resp_valid, to_resp_fault, to_resp_misalign;
    logic [31:0] to_resp_rdata, to_mem_addr, to_mem_wdata;
    logic        to_mem_req, to_mem_we, to_mem_gnt, to_mem_rvalid;
    logic [3:0]  to_mem_wstrb;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        mis;
    } exp_t;
    exp_t sb_q[$];

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT(256)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .halt(halt),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .resp_misalign(resp_misalign),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst),
        .req_valid(to_req_valid), .req_ready(to_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .halt(halt),
        .resp_valid(to_resp_valid), .resp_rdata(to_resp_rdata), .resp_fault(to_resp_fault),
        .resp_misalign(to_resp_misalign),
        .mem_req(to_mem_req), .mem_gnt(to_mem_gnt), .mem_addr(to_mem_addr), .mem_we(to_mem_we),
        .mem_wstrb(to_mem_wstrb), .mem_wdata(to_mem_wdata), .mem_rvalid(to_mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Response monitor: every resp_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got resp rdata=%h fault=%b, want no response", resp_rdata, resp_fault);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (resp_rdata !== e.rdata || resp_fault !== e.fault || resp_misalign !== e.mis) begin
                    errors++;
                    $display("FAIL resp_data: got rdata=%h fault=%b mis=%b, want rdata=%h fault=%b mis=%b",
                             resp_rdata, resp_fault, resp_misalign, e.rdata, e.fault, e.mis);
                end
            end
        end
    end

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b resp_valid=%b mem_req=%b, want 1 0 0", req_ready, resp_valid, mem_req);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0 ||
            resp_rdata !== 32'h0 || resp_fault !== 1'b0 || resp_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h strb=%b wdata=%h rdata=%h fault=%b, want all zero",
                     mem_addr, mem_wstrb, mem_wdata, resp_rdata, resp_fault);
        end
    endtask

    // One complete transaction with a chosen grant delay and read-data delay (rv_dly >= 1).
    task automatic test_txn(input string name, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                            input int gnt_dly, input int rv_dly, input logic [31:0] e_addr,
                            input logic [3:0] e_strb, input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        exp_t e;
        @(negedge clk);
        drive_req(we, sz, uns, addr, wd);
        req_valid = 1'b1;
        e.rdata = we ? 32'h0 : e_rdata;
        e.fault = 1'b0;
        e.mis   = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'h0;
        for (int i = 0; i <= gnt_dly; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== e_addr ||
                (we && (mem_wstrb !== e_strb || mem_wdata !== e_wdata))) begin
                errors++;
                $display("FAIL %s_bus[%0d]: got req=%b we=%b addr=%h strb=%b wdata=%h, want 1 %b %h %b %h",
                         name, i, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, we, e_addr, e_strb, e_wdata);
            end
            if (i == gnt_dly) mem_gnt = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 1'b0;
        if (!we) begin
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s_wait_req: got mem_req=%b, want 0", name, mem_req);
            end
            repeat (rv_dly - 1) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(posedge clk);
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency: got resp_valid=%b ready=%b, want 1 0", name, resp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after: got resp_valid=%b ready=%b, want 0 1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_fault_at_accept(input string name, input logic [1:0] sz,
                                        input logic [31:0] addr, input logic e_mis);
        exp_t e;
        @(negedge clk);
        drive_req(1'b0, sz, 1'b0, addr, 32'h0);
        req_valid = 1'b1;
        e.rdata = 32'h0;
        e.fault = 1'b1;
        e.mis   = e_mis;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_resp: got resp_valid=%b mem_req=%b, want 1 0", name, resp_valid, mem_req);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: got resp_valid=%b mem_req=%b, want 0 0", name, resp_valid, mem_req);
        end
    endtask

    task automatic test_halt;
        exp_t e;
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1111_2222);
        halt      = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_block[%0d]: got ready=%b mem_req=%b resp=%b, want 0 0 0",
                         i, req_ready, mem_req, resp_valid);
            end
        end
        halt = 1'b0;
        e.rdata = 32'h0;
        e.fault = 1'b0;
        e.mis   = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        halt      = 1'b1;
        mem_gnt   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_inflight: got resp_valid=%b ready=%b, want 1 0", resp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_idle_ready: got ready=%b, want 0", req_ready);
        end
        halt = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got resp=%b mem_req=%b ready=%b, want 0 0 1", resp_valid, mem_req, req_ready);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_rvalid: got resp=%b ready=%b, want 0 1", resp_valid, req_ready);
        end
    endtask

    // Runs on the TIMEOUT=4 instance; gnt_at >= 4 means the grant never comes.
    task automatic test_timeout(input string name, input int gnt_at);
        @(negedge clk);
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        to_req_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            to_req_valid = 1'b0;
            checks++;
            if (to_mem_req !== (i <= gnt_at) || to_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_cyc[%0d]: got mem_req=%b resp=%b, want %b 0",
                         name, i, to_mem_req, to_resp_valid, (i <= gnt_at));
            end
            to_mem_gnt = (i == gnt_at);
        end
        @(negedge clk);
        to_mem_gnt = 1'b0;
        checks++;
        if (to_resp_valid !== 1'b1 || to_resp_fault !== 1'b1 || to_resp_rdata !== 32'h0 ||
            to_resp_misalign !== 1'b0 || to_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_fault: got resp=%b fault=%b mis=%b rdata=%h mem_req=%b, want 1 1 0 0 0",
                     name, to_resp_valid, to_resp_fault, to_resp_misalign, to_resp_rdata, to_mem_req);
        end
        @(negedge clk);
        checks++;
        if (to_resp_valid !== 1'b0 || to_mem_req !== 1'b0 || to_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after: got resp=%b mem_req=%b ready=%b, want 0 0 1",
                     name, to_resp_valid, to_mem_req, to_req_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; halt = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        to_req_valid = 1'b0; to_mem_gnt = 1'b0; to_mem_rvalid = 1'b0;

        test_reset();
        test_txn("st_b103", 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 0, 1,
                 32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        test_txn("st_h102", 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_BEEF, 32'h0, 0, 1,
                 32'h100, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        test_txn("st_b100", 1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_005A, 32'h0, 2, 1,
                 32'h100, 4'b0001, 32'h5A5A_5A5A, 32'h0);
        test_txn("st_stall", 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h0, 5, 1,
                 32'h200, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        test_txn("ld_h_s", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h8001_1234, 0, 3,
                 32'h100, 4'b0000, 32'h0, 32'hFFFF_8001);
        test_txn("ld_h_u", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h8001_1234, 0, 3,
                 32'h100, 4'b0000, 32'h0, 32'h0000_8001);
        test_txn("ld_b_s", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0000_8000, 1, 1,
                 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
        test_txn("ld_b_u", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hF000_0000, 0, 2,
                 32'h100, 4'b0000, 32'h0, 32'h0000_00F0);
        test_txn("ld_w", 1'b0, 2'b10, 1'b1, 32'h104, 32'h0, 32'h1234_5678, 3, 1,
                 32'h104, 4'b0000, 32'h0, 32'h1234_5678);
        test_fault_at_accept("rsvd_size", 2'b11, 32'h100, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        test_fault_at_accept("mis_w102", 2'b10, 32'h102, 1'b1);
        test_fault_at_accept("mis_h101", 2'b01, 32'h101, 1'b1);
`else
        test_txn("ld_w102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hCAFE_F00D, 0, 1,
                 32'h100, 4'b0000, 32'h0, 32'hCAFE_F00D);
        test_txn("ld_h101", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0000_9ABC, 0, 1,
                 32'h100, 4'b0000, 32'h0, 32'hFFFF_9ABC);
`endif
        test_halt();
        test_reset_mid();
        test_timeout("to_req", 99);
        test_timeout("to_wait", 0);

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding responses, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
